// File: rtl/fifo_pkt_framer.sv
// Packet framer that drains a first-word-fall-through FIFO into a valid/ready stream.
// Words are grouped into packets of pkt_len beats; a stalled packet is closed with a pad beat.
module fifo_pkt_framer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LEN_WIDTH     = 8,
  parameter int                    TIMEOUT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [LEN_WIDTH-1:0]     pkt_len,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     m_pad,
  output logic                     busy,
  output logic [15:0]              pkt_cnt
);

  typedef enum logic {IDLE, SEND} state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [LEN_WIDTH-1:0]     beat_q, beat_d;
  logic [TIMEOUT_WIDTH-1:0] idle_q, idle_d;
  logic                     pad_pending_q, pad_pending_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     pad_q, pad_d;
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;

  logic                     out_free;
  logic                     timeout_hit;
  logic                     pad_pending;
  logic                     pop;
  logic                     pad_load;
  logic [LEN_WIDTH-1:0]     len_eff;

  // The pending flag is sticky so a pad is not lost if the idle counter moves on during a stall.
  assign out_free    = ~valid_q | m_ready;
  assign timeout_hit = (state_q == SEND) && (timeout != '0) && (idle_q == timeout);
  assign pad_pending = pad_pending_q | timeout_hit;
  assign pop         = ~rst & ~fifo_empty & out_free & ~pad_pending;
  assign pad_load    = pad_pending & out_free;
  assign len_eff     = (pkt_len == '0) ? LEN_ONE : pkt_len;

  assign fifo_rd_en = pop;
  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign m_last     = last_q;
  assign m_pad      = pad_q;
  assign busy       = (state_q == SEND);
  assign pkt_cnt    = pkt_cnt_q;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    idle_d        = idle_q;
    pad_pending_d = pad_pending;
    data_d        = data_q;
    valid_d       = valid_q;
    last_d        = last_q;
    pad_d         = pad_q;
    pkt_cnt_d     = pkt_cnt_q;

    if (valid_q && m_ready && last_q) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end

    // A pad always takes priority over a word that shows up in the same cycle.
    if (pad_load) begin
      data_d        = PAD_VALUE;
      valid_d       = 1'b1;
      last_d        = 1'b1;
      pad_d         = 1'b1;
      state_d       = IDLE;
      pad_pending_d = 1'b0;
      beat_d        = '0;
    end else if (pop) begin
      data_d  = fifo_dout;
      valid_d = 1'b1;
      pad_d   = 1'b0;
      idle_d  = '0;
      case (state_q)
        IDLE: begin
          len_d  = len_eff;
          beat_d = LEN_ONE;
          if (len_eff == LEN_ONE) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            last_d  = 1'b0;
            state_d = SEND;
          end
        end
        SEND: begin
          beat_d = beat_q + LEN_ONE;
          if (beat_q == len_q - LEN_ONE) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            last_d  = 1'b0;
            state_d = SEND;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q == SEND) && fifo_empty && (idle_q != '1)) begin
      idle_d = idle_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      beat_q        <= '0;
      idle_q        <= '0;
      pad_pending_q <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      pad_q         <= 1'b0;
      pkt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      idle_q        <= idle_d;
      pad_pending_q <= pad_pending_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      pad_q         <= pad_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Directed bench for fifo_pkt_framer: an FWFT FIFO model feeds the DUT and a scoreboard
// of expected beats is checked at every stream handshake.
module tb_fifo_pkt_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifoDout;
  logic        fifoEmpty;
  logic        fifoRdEn;
  logic [7:0]  pktLen;
  logic [15:0] timeout;
  logic [7:0]  mData;
  logic        mValid;
  logic        mReady;
  logic        mLast;
  logic        mPad;
  logic        busy;
  logic [15:0] pktCnt;

  always #5 clk = ~clk;

  fifo_pkt_framer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifoDout),
    .fifo_empty (fifoEmpty),
    .fifo_rd_en (fifoRdEn),
    .pkt_len    (pktLen),
    .timeout    (timeout),
    .m_data     (mData),
    .m_valid    (mValid),
    .m_ready    (mReady),
    .m_last     (mLast),
    .m_pad      (mPad),
    .busy       (busy),
    .pkt_cnt    (pktCnt)
  );

  logic [7:0] wrData[$];
  logic [7:0] fifoMem[$];
  int         wrTaken;

  // FIFO model: pops follow fifo_rd_en at each edge, writes become visible one edge later.
  initial begin : fifoModel
    logic popNow;
    wrTaken   = 0;
    fifoEmpty = 1'b1;
    fifoDout  = 8'h00;
    forever begin
      @(posedge clk);
      popNow = fifoRdEn;
      #1;
      if (popNow && fifoMem.size() > 0) void'(fifoMem.pop_front());
      while (wrTaken < wrData.size()) begin
        fifoMem.push_back(wrData[wrTaken]);
        wrTaken++;
      end
      fifoEmpty = (fifoMem.size() == 0);
      fifoDout  = fifoEmpty ? 8'h00 : fifoMem[0];
    end
  end

  logic [9:0] expQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         expBeat = 0;
  int         expLen = 1;
  int         expPkts = 0;
  int         cycleNo = 0;
  int         hsCount = 0;
  int         firstHs = 0;
  int         lastHs = 0;
  int         gapHs = 0;
  logic       stalled = 1'b0;
  logic [9:0] holdBeat;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [7:0] d);
    logic last;
    if (expBeat == 0) expLen = (pktLen == 8'd0) ? 1 : int'(pktLen);
    expBeat++;
    last = (expBeat == expLen);
    if (last) expBeat = 0;
    expQ.push_back({d, last, 1'b0});
    wrData.push_back(d);
  endtask

  task automatic pushPad();
    expQ.push_back({8'h00, 1'b1, 1'b1});
    expBeat = 0;
  endtask

  // One cycle: drive m_ready at the falling edge, then check what the next rising edge will accept.
  task automatic applyStimulus(input logic rdy);
    logic [9:0] e;
    @(negedge clk);
    cycleNo++;
    mReady = rdy;
    #1;
    if (stalled) checkOutput("stall_hold", {mValid, mData, mLast, mPad}, {1'b1, holdBeat});
    if (mValid && !mReady) begin
      checkOutput("rd_en_in_stall", {31'd0, fifoRdEn}, 32'd0);
      stalled  = 1'b1;
      holdBeat = {mData, mLast, mPad};
    end else begin
      stalled = 1'b0;
    end
    if (mValid && mReady) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL unexpected_beat observed=0x%0h expected=none", {mData, mLast, mPad});
      end else begin
        e = expQ.pop_front();
        checkOutput("beat", {22'd0, mData, mLast, mPad}, {22'd0, e});
        if (e[1]) expPkts++;
        if (hsCount == 0) firstHs = cycleNo;
        gapHs  = cycleNo - lastHs;
        lastHs = cycleNo;
        hsCount++;
      end
    end
  endtask

  task automatic drain(input int budget, input bit toggleReady);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      applyStimulus(toggleReady ? logic'(n % 2 == 0) : 1'b1);
      n++;
    end
    checkOutput("drain_done", expQ.size(), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    mReady  = 1'b0;
    pktLen  = 8'd4;
    timeout = 16'd0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, mValid}, 32'd0);
    checkOutput("rst_data", {24'd0, mData}, 32'd0);
    checkOutput("rst_flags", {30'd0, mLast, mPad}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_pkt_cnt", {16'd0, pktCnt}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, fifoRdEn}, 32'd0);
    rst = 1'b0;

    $display("[TB] two back-to-back 4-word packets at full rate");
    hsCount = 0;
    for (int i = 0; i < 8; i++) pushWord(8'h10 + 8'(i));
    drain(40, 1'b0);
    checkOutput("full_rate_beats", hsCount, 32'd8);
    checkOutput("full_rate_span", lastHs - firstHs, 32'd7);
    checkOutput("busy_after_last", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1);
    checkOutput("pkt_cnt_a", {16'd0, pktCnt}, expPkts);

    $display("[TB] same words with m_ready toggling");
    for (int i = 0; i < 8; i++) pushWord(8'h10 + 8'(i));
    drain(60, 1'b1);
    applyStimulus(1'b1);
    checkOutput("pkt_cnt_b", {16'd0, pktCnt}, expPkts);

    $display("[TB] timeout closes a short packet with a pad beat");
    timeout = 16'd5;
    pushWord(8'h21);
    pushWord(8'h22);
    pushPad();
    drain(40, 1'b0);
    checkOutput("pad_gap", gapHs, 32'd6);
    applyStimulus(1'b1);
    checkOutput("pkt_cnt_c", {16'd0, pktCnt}, 32'd5);
    checkOutput("busy_after_pad", {31'd0, busy}, 32'd0);
    pushWord(8'h23);
    drain(10, 1'b0);
    checkOutput("busy_new_pkt", {31'd0, busy}, 32'd1);
    pushPad();
    drain(20, 1'b0);
    applyStimulus(1'b1);
    checkOutput("pkt_cnt_c2", {16'd0, pktCnt}, expPkts);

    $display("[TB] long FIFO gap with timeout disabled");
    timeout = 16'd0;
    pushWord(8'h31);
    pushWord(8'h32);
    repeat (100) applyStimulus(1'b1);
    checkOutput("gap_busy", {31'd0, busy}, 32'd1);
    checkOutput("gap_no_valid", {31'd0, mValid}, 32'd0);
    pushWord(8'h33);
    pushWord(8'h34);
    drain(20, 1'b0);
    applyStimulus(1'b1);
    checkOutput("pkt_cnt_d", {16'd0, pktCnt}, 32'd7);

    $display("[TB] pkt_len of zero gives single-beat packets");
    pktLen  = 8'd0;
    hsCount = 0;
    for (int i = 0; i < 3; i++) pushWord(8'h41 + 8'(i));
    drain(20, 1'b0);
    applyStimulus(1'b1);
    checkOutput("len0_beats", hsCount, 32'd3);
    checkOutput("pkt_cnt_e", {16'd0, pktCnt}, 32'd10);

    $display("[TB] reset in the middle of a packet");
    pktLen = 8'd4;
    pushWord(8'hA1);
    pushWord(8'hA2);
    drain(20, 1'b0);
    checkOutput("mid_pkt_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'd0, mValid}, 32'd0);
    checkOutput("midrst_data", {24'd0, mData}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_pkt_cnt", {16'd0, pktCnt}, 32'd0);
    expPkts = 0;
    expBeat = 0;
    stalled = 1'b0;
    for (int i = 0; i < 4; i++) pushWord(8'hB1 + 8'(i));
    repeat (2) @(negedge clk);
    #1;
    checkOutput("midrst_fifo_loaded", {31'd0, fifoEmpty}, 32'd0);
    checkOutput("midrst_rd_en", {31'd0, fifoRdEn}, 32'd0);
    rst = 1'b0;
    drain(20, 1'b0);
    applyStimulus(1'b1);
    checkOutput("pkt_cnt_f", {16'd0, pktCnt}, 32'd1);
    checkOutput("busy_end", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_framer.md
Name: fifo_pkt_framer

Overview:
- Downstream consumer of the first-word-fall-through (FWFT) sync FIFO.
- Pops words from the FIFO read port and frames them into packets of a programmable length, presented on a valid/ready stream with last/pad flags.
- If the FIFO runs dry mid-packet for longer than a programmable timeout, the packet is closed with a pad word, so downstream packet logic never stalls forever.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- LEN_WIDTH, 8, width of pkt_len and of the internal beat counter.
- TIMEOUT_WIDTH, 16, width of timeout and of the idle counter.
- PAD_VALUE, 0, data value driven on m_data for a timeout pad word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- fifo_dout  in  DATA_WIDTH  FWFT FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe to FIFO; combinational.
- pkt_len  in  LEN_WIDTH  words per packet; sampled at packet start; 0 is treated as 1.
- timeout  in  TIMEOUT_WIDTH  empty-cycle limit mid-packet; 0 disables the timeout.
- m_data  out  DATA_WIDTH  stream data, registered.
- m_valid  out  1  stream valid, registered.
- m_ready  in  1  stream ready.
- m_last  out  1  final beat of packet, registered.
- m_pad  out  1  beat is a timeout pad word (m_last is also 1), registered.
- busy  out  1  state==SEND.
- pkt_cnt  out  16  count of completed packets; wraps at 0xFFFF->0.

Behaviour:
- Reset values:
  - state=IDLE.
  - m_valid=0, m_data=0, m_last=0, m_pad=0.
  - pkt_cnt=0, beat counter=0, idle counter=0.
  - busy=0.
  - fifo_rd_en forced to 0 while rst=1.
- Output register (single stage):
  - out_free = ~m_valid | m_ready.
  - On a load, m_valid=1 with the new data/flags.
  - If m_valid & m_ready and no load: m_valid<=0.
  - While m_valid & ~m_ready: m_data, m_last and m_pad are held stable.
- Pop rule:
  - fifo_rd_en = ~rst & ~fifo_empty & out_free & (state==IDLE | state==SEND) & ~pad_pending.
  - A pop loads fifo_dout into m_data on the same clock edge.
- FSM states: IDLE, SEND.
- IDLE:
  - On pop: latch len_q = max(pkt_len,1) and beat counter<=1.
  - If len_q==1: m_last=1 and stay in IDLE.
  - Otherwise: m_last=0 and go to SEND.
  - There is no bubble between packets.
- SEND, on pop:
  - Beat counter increments.
  - If beat counter == len_q-1 before the increment: m_last=1, go to IDLE.
- Latency: first word available with state IDLE at cycle t appears on m_valid at t+1.
- Throughput: with m_ready=1 and the FIFO non-empty, 1 word/cycle sustained, including across packet boundaries.
- Idle counter (SEND only):
  - Cleared on every pop and on entering SEND.
  - Increments on each SEND cycle with fifo_empty=1.
  - Holds otherwise; saturates at all-ones.
- Timeout:
  - When timeout!=0 and idle counter == timeout, pad_pending=1 and popping is blocked.
  - When out_free, load m_data=PAD_VALUE, m_last=1, m_pad=1, go to IDLE, and clear pad_pending.
  - If the FIFO becomes non-empty in the same cycle pad_pending is set, the pad still wins.
- pkt_cnt increments on each m_valid & m_ready & m_last handshake.
- pkt_len and timeout changes mid-packet:
  - pkt_len: ignored until the next packet start.
  - timeout: the live value is compared each cycle.
- rst mid-packet: all state is cleared immediately. Any held word is dropped. The next word popped starts a new packet with beat count 1.

Test Plan:
- pkt_len=4, timeout=0, FIFO preloaded 0x10..0x17, m_ready=1 -> 8 consecutive m_valid beats; m_last=1 only on 0x13 and 0x17; pkt_cnt=2; busy low after the last pop.
- Same preload, m_ready toggled 1,0,1,0... -> every word delivered once in order; m_data stable during stalls; fifo_rd_en=0 whenever m_valid=1 & m_ready=0.
- pkt_len=4, timeout=5, only 0x21,0x22 written -> exactly 5 empty cycles after the second pop, then beat PAD_VALUE with m_last=1, m_pad=1; pkt_cnt=1. A later write of 0x23 starts a new packet.
- pkt_len=4, timeout=0, words 0x31,0x32, then 0x33,0x34 written 100 cycles later -> no pad; one 4-beat packet with m_last on 0x34.
- pkt_len=0, words 0x41..0x43 -> three single-beat packets, each with m_last=1; pkt_cnt=3.
- rst pulsed after 2 beats of a 4-word packet -> outputs return to reset values within the same cycle; fifo_rd_en=0 during rst. The next 4 words form a complete packet with m_last on the 4th.
